// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register sequencer and its watchdog.
package i2c_seq_pkg;

  localparam logic [6:0] DEVICE_ADDRESS_DEFAULT = 7'h33;
  localparam int         LEN_W_DEFAULT          = 11;
  localparam int         TIMEOUT_CYCLES_DEFAULT = 200000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_IDLE = 4'd1,
    S_REG_HI    = 4'd2,
    S_REG_LO    = 4'd3,
    S_WR_HI     = 4'd4,
    S_WR_LO     = 4'd5,
    S_RESTART   = 4'd6,
    S_READ      = 4'd7,
    S_FINISH    = 4'd8,
    S_DONE      = 4'd9
  } seq_state_e;

  // Bits needed to hold TIMEOUT_CYCLES-1.
  function automatic int timeout_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Loadable down-counter; expired is high once the count has run down to zero.
module i2c_seq_watchdog
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int               CNT_W  = timeout_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and hold at zero.
  always_comb begin
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != ZERO) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == ZERO);

endmodule

// File: rtl/i2c_register_sequencer.sv
// Turns one register-write or burst-read command into the byte-level
// enable/ack handshake of i2c_controller and streams read bytes out.
module i2c_register_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = DEVICE_ADDRESS_DEFAULT,
  parameter int         LEN_W          = LEN_W_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_reg_addr,
  input  logic [15:0]      cmd_wdata,
  input  logic [LEN_W-1:0] cmd_length,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             done,
  output logic             error,
  output logic             busy,
  input  logic             i2c_idle,
  input  logic             i2c_ack,
  input  logic             i2c_nack,
  input  logic [7:0]       i2c_received_data,
  output logic [6:0]       i2c_address,
  output logic             i2c_read_write,
  output logic [7:0]       i2c_transmit_data,
  output logic             i2c_enable_transfer,
  output logic             i2c_issue_restart
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  seq_state_e       state_q, state_d, prev_state_q, prev_state_d;
  logic             ack_q, ack_d, wr_q, wr_d, err_q, err_d;
  logic [15:0]      reg_addr_q, reg_addr_d, wdata_q, wdata_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [1:0]       hold_q, hold_d;
  logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [7:0]       rd_data_q, rd_data_d, txd_q, txd_d;
  logic             done_q, done_d, error_q, error_d;
  logic             enable_q, enable_d, rw_q, rw_d, restart_q, restart_d;
  logic             ack_evt_s, in_xfer_s, wd_load_s, wd_expired_s, timeout_s, abort_s;

  assign ack_evt_s = i2c_ack && !ack_q;
  assign in_xfer_s = (state_q != S_IDLE) && (state_q != S_FINISH) && (state_q != S_DONE);
  // Progress (state change or byte ack) rearms the watchdog; it is parked outside a transfer.
  assign wd_load_s = (state_q != prev_state_q) || ack_evt_s ||
                     (state_q == S_IDLE) || (state_q == S_DONE);
  assign timeout_s = wd_expired_s && !wd_load_s;
  assign abort_s   = in_xfer_s && (i2c_nack || timeout_s);

  i2c_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wd_load_s),
    .expired (wd_expired_s)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    prev_state_d = state_q;
    ack_d        = i2c_ack;
    wr_d         = wr_q;
    err_d        = err_q;
    reg_addr_d   = reg_addr_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    hold_d       = hold_q;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;
    rd_data_d    = rd_data_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    txd_d        = txd_q;
    enable_d     = enable_q;
    rw_d         = rw_q;
    restart_d    = restart_q;
    if (abort_s) begin
      // NACK wins over a coincident ack, so no byte is streamed here.
      enable_d  = 1'b0;
      restart_d = 1'b0;
      err_d     = 1'b1;
      state_d   = S_FINISH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            wr_d       = cmd_write;
            reg_addr_d = cmd_reg_addr;
            wdata_d    = cmd_wdata;
            count_d    = cmd_length;
            err_d      = 1'b0;
            txd_d      = cmd_reg_addr[15:8];
            state_d    = (!cmd_write && (cmd_length == LEN_ZERO)) ? S_DONE : S_WAIT_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (i2c_idle) begin
            enable_d  = 1'b1;
            rw_d      = 1'b0;
            txd_d     = reg_addr_q[15:8];
            restart_d = 1'b0;
            state_d   = S_REG_HI;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
        S_REG_HI: begin
          if (ack_evt_s) begin
            txd_d   = reg_addr_q[7:0];
            state_d = S_REG_LO;
          end else begin
            state_d = S_REG_HI;
          end
        end
        S_REG_LO: begin
          if (ack_evt_s && wr_q) begin
            txd_d   = wdata_q[15:8];
            state_d = S_WR_HI;
          end else if (ack_evt_s) begin
            enable_d  = 1'b0;
            restart_d = 1'b1;
            hold_d    = 2'd0;
            state_d   = S_RESTART;
          end else begin
            state_d = S_REG_LO;
          end
        end
        S_WR_HI: begin
          if (ack_evt_s) begin
            txd_d   = wdata_q[7:0];
            state_d = S_WR_LO;
          end else begin
            state_d = S_WR_HI;
          end
        end
        S_WR_LO: begin
          if (ack_evt_s) begin
            enable_d  = 1'b0;
            restart_d = 1'b0;
            state_d   = S_FINISH;
          end else begin
            state_d = S_WR_LO;
          end
        end
        S_RESTART: begin
          // Dwell two cycles so i2c_idle reflects the controller after its STOP.
          if ((hold_q == 2'd2) && i2c_idle) begin
            enable_d  = 1'b1;
            rw_d      = 1'b1;
            restart_d = 1'b0;
            state_d   = S_READ;
          end else begin
            hold_d  = (hold_q == 2'd2) ? hold_q : hold_q + 2'd1;
            state_d = S_RESTART;
          end
        end
        S_READ: begin
          if (ack_evt_s) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i2c_received_data;
            count_d    = count_q - LEN_ONE;
            if (count_q == LEN_ONE) begin
              // Enable falls with the last byte so the controller NACKs it.
              rd_last_d = 1'b1;
              enable_d  = 1'b0;
              state_d   = S_FINISH;
            end else begin
              state_d = S_READ;
            end
          end else begin
            state_d = S_READ;
          end
        end
        S_FINISH: begin
          if (i2c_idle) begin
            state_d = S_DONE;
          end else if (timeout_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FINISH;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          error_d = err_q;
          state_d = S_IDLE;
        end
        default: begin
          enable_d = 1'b0;
          state_d  = S_IDLE;
        end
      endcase
    end
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, command latches and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      prev_state_q <= S_IDLE;
      ack_q        <= 1'b0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      reg_addr_q   <= 16'h0000;
      wdata_q      <= 16'h0000;
      count_q      <= LEN_ZERO;
      hold_q       <= 2'd0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= 8'h00;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      txd_q        <= 8'h00;
      enable_q     <= 1'b0;
      rw_q         <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= prev_state_d;
      ack_q        <= ack_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      reg_addr_q   <= reg_addr_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data_q    <= rd_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
      txd_q        <= txd_d;
      enable_q     <= enable_d;
      rw_q         <= rw_d;
      restart_q    <= restart_d;
    end
  end

  assign cmd_ready           = cmd_ready_q;
  assign busy                = busy_q;
  assign rd_valid            = rd_valid_q;
  assign rd_last             = rd_last_q;
  assign rd_data             = rd_data_q;
  assign done                = done_q;
  assign error               = error_q;
  assign i2c_address         = DEVICE_ADDRESS;
  assign i2c_read_write      = rw_q;
  assign i2c_transmit_data   = txd_q;
  assign i2c_enable_transfer = enable_q;
  assign i2c_issue_restart   = restart_q;

endmodule

// File: tb/tb_i2c_register_sequencer.sv
// Directed bench: behavioural controller+peripheral model, scoreboard queues for
// written bytes, read bytes and transfer starts.
module tb_i2c_register_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_reg_addr, cmd_wdata;
  logic [10:0] cmd_length;
  logic        rd_valid, rd_last, done, error, busy;
  logic [7:0]  rd_data;
  logic [6:0]  i2c_address;
  logic        i2c_read_write, i2c_enable_transfer, i2c_issue_restart;
  logic [7:0]  i2c_transmit_data;

  // controller/peripheral model state
  logic        m_idle, m_ack, m_nack, m_rw;
  logic [7:0]  m_rxd;
  int          m_st, m_tmr;
  int          m_rd_idx = 0;
  int          m_mnack = 0;
  logic [7:0]  slave_mem [0:63];
  logic        cfg_nack, cfg_hold;

  // scoreboard
  logic [8:0]  exp_rd[$], obs_rd[$];
  logic [7:0]  exp_wr[$], wr_log[$];
  logic        exp_start[$], start_log[$], done_log[$];
  int          obs_base = 0, wr_base = 0, start_base = 0;
  int          en_cnt = 0, both_cnt = 0;
  int          n_cmp = 0, n_err = 0;

  logic [24:0] outs_s;
  assign outs_s = {cmd_ready, rd_valid, rd_data, rd_last, done, error, busy,
                   i2c_read_write, i2c_transmit_data, i2c_enable_transfer, i2c_issue_restart};

  always #5 clk = ~clk;

  i2c_register_sequencer #(.DEVICE_ADDRESS(7'h33), .LEN_W(11), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata), .cmd_length(cmd_length),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .error(error), .busy(busy),
    .i2c_idle(m_idle), .i2c_ack(m_ack), .i2c_nack(m_nack), .i2c_received_data(m_rxd),
    .i2c_address(i2c_address), .i2c_read_write(i2c_read_write),
    .i2c_transmit_data(i2c_transmit_data), .i2c_enable_transfer(i2c_enable_transfer),
    .i2c_issue_restart(i2c_issue_restart)
  );

  // Controller model: address phase, one ack per data byte, master NACK when enable is low after a read byte.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 0; m_tmr <= 0; m_idle <= 1'b1; m_ack <= 1'b0; m_nack <= 1'b0; m_rxd <= 8'h00; m_rw <= 1'b0;
    end else begin
      m_nack <= 1'b0;
      case (m_st)
        0: if (i2c_enable_transfer) begin
             m_idle <= 1'b0; m_rw <= i2c_read_write; start_log.push_back(i2c_read_write);
             m_tmr <= 4; m_st <= 1;
           end
        1: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else if (cfg_nack) begin m_nack <= 1'b1; m_tmr <= 4; m_st <= 5; end
           else if (cfg_hold) m_st <= 6;
           else begin m_tmr <= 4; m_st <= 2; end
        2: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else begin
             if (!m_rw) wr_log.push_back(i2c_transmit_data);
             else begin m_rxd <= slave_mem[m_rd_idx % 64]; m_rd_idx <= m_rd_idx + 1; end
             m_ack <= 1'b1; m_tmr <= 2; m_st <= 3;
           end
        3: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else begin m_ack <= 1'b0; m_tmr <= 3; m_st <= 4; end
        4: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else if (i2c_enable_transfer) begin m_tmr <= 4; m_st <= 2; end
           else begin
             if (m_rw) m_mnack <= m_mnack + 1;
             m_tmr <= 4; m_st <= 5;
           end
        5: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else begin m_idle <= 1'b1; m_st <= 0; end
        6: if (!i2c_enable_transfer) begin m_tmr <= 4; m_st <= 5; end
        default: m_st <= 0;
      endcase
    end
  end

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rd_valid) obs_rd.push_back({rd_last, rd_data});
    if (done) done_log.push_back(error);
    if (i2c_enable_transfer) en_cnt++;
    if (rd_valid && done) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put_slave(input int k, input logic [7:0] b);
    slave_mem[(m_rd_idx + k) % 64] = b;
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] ra, input logic [15:0] wd,
                          input logic [10:0] len);
    int n;
    @(negedge clk);
    cmd_write = wr; cmd_reg_addr = ra; cmd_wdata = wd; cmd_length = len; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("accept_busy", {busy, cmd_ready}, 2'b10);
  endtask

  task automatic wait_done(input int d0, input int bound, output logic err, output int lat);
    lat = 0;
    while (done_log.size() == d0 && lat < bound) begin @(negedge clk); lat++; end
    check("done_seen", (done_log.size() > d0), 1'b1);
    err = (done_log.size() > d0) ? done_log[d0] : 1'bx;
  endtask

  task automatic check_sb(input string tag);
    logic [8:0] er; logic [7:0] ew; logic es;
    check({tag, "_rd_cnt"}, obs_rd.size() - obs_base, exp_rd.size());
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front();
      if (obs_base < obs_rd.size()) check({tag, "_rd"}, obs_rd[obs_base], er);
      obs_base++;
    end
    obs_base = obs_rd.size();
    check({tag, "_wr_cnt"}, wr_log.size() - wr_base, exp_wr.size());
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      if (wr_base < wr_log.size()) check({tag, "_wr"}, wr_log[wr_base], ew);
      wr_base++;
    end
    wr_base = wr_log.size();
    check({tag, "_start_cnt"}, start_log.size() - start_base, exp_start.size());
    while (exp_start.size() > 0) begin
      es = exp_start.pop_front();
      if (start_base < start_log.size()) check({tag, "_start_rw"}, start_log[start_base], es);
      start_base++;
    end
    start_base = start_log.size();
  endtask

  initial begin
    logic       err;
    int         lat, d0, mn0, en0, n;
    logic [7:0] burst [0:3];
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_reg_addr = 16'h0000;
    cmd_wdata = 16'h0000; cmd_length = 11'd0; cfg_nack = 1'b0; cfg_hold = 1'b0;
    #7;
    check("reset_outs", outs_s, 25'h0);
    check("dev_addr", i2c_address, 7'h33);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {busy, cmd_ready}, 2'b01);

    // 1: register write
    exp_wr = '{8'h80, 8'h0D, 8'h19, 8'h01}; exp_start = '{1'b0};
    d0 = done_log.size();
    send_cmd(1'b1, 16'h800D, 16'h1901, 11'd0);
    wait_done(d0, 400, err, lat);
    check("wr_error", err, 1'b0);
    check_sb("wr");

    // 2: burst read of 4
    burst = '{8'hAA, 8'h55, 8'h12, 8'h34};
    for (int i = 0; i < 4; i++) begin
      put_slave(i, burst[i]);
      exp_rd.push_back({(i == 3), burst[i]});
    end
    exp_wr = '{8'h04, 8'h00}; exp_start = '{1'b0, 1'b1};
    mn0 = m_mnack; d0 = done_log.size();
    send_cmd(1'b0, 16'h0400, 16'h0000, 11'd4);
    wait_done(d0, 600, err, lat);
    check("rd_error", err, 1'b0);
    check("rd_master_nack", m_mnack - mn0, 1);
    check_sb("rd");

    // 3: address NACK on a read command
    cfg_nack = 1'b1;
    exp_start = '{1'b0};
    d0 = done_log.size();
    send_cmd(1'b0, 16'h0400, 16'h0000, 11'd4);
    wait_done(d0, 400, err, lat);
    cfg_nack = 1'b0;
    check("nack_error", err, 1'b1);
    check("nack_enable_low", i2c_enable_transfer, 1'b0);
    check_sb("nack");
    repeat (2) @(negedge clk);
    check("nack_ready", cmd_ready, 1'b1);

    // 4: zero-length read
    en0 = en_cnt; d0 = done_log.size();
    send_cmd(1'b0, 16'h0400, 16'h0000, 11'd0);
    wait_done(d0, 20, err, lat);
    check("len0_error", err, 1'b0);
    check("len0_latency_le2", (lat <= 2), 1'b1);
    check("len0_no_enable", en_cnt - en0, 0);
    check_sb("len0");

    // 5: peripheral holds off, watchdog aborts
    cfg_hold = 1'b1;
    exp_start = '{1'b0};
    d0 = done_log.size();
    send_cmd(1'b1, 16'h800D, 16'h1901, 11'd0);
    wait_done(d0, 3000, err, lat);
    cfg_hold = 1'b0;
    check("tmo_error", err, 1'b1);
    check("tmo_window", (lat >= 1000 && lat <= 1040), 1'b1);
    check_sb("tmo");

    // 6: reset during byte 3 of an 8-byte burst, then a clean 2-byte read
    for (int i = 0; i < 8; i++) put_slave(i, 8'h10 + 8'(i));
    send_cmd(1'b0, 16'h0400, 16'h0000, 11'd8);
    n = 0;
    while (obs_rd.size() < obs_base + 2 && n < 600) begin @(negedge clk); n++; end
    check("mid_two_bytes", (obs_rd.size() >= obs_base + 2), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", outs_s, 25'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    obs_base = obs_rd.size(); wr_base = wr_log.size(); start_base = start_log.size();
    repeat (2) @(negedge clk);
    check("post_reset_ready", cmd_ready, 1'b1);
    put_slave(0, 8'hAB); put_slave(1, 8'hCD);
    exp_rd = '{{1'b0, 8'hAB}, {1'b1, 8'hCD}};
    exp_wr = '{8'h04, 8'h00}; exp_start = '{1'b0, 1'b1};
    mn0 = m_mnack; d0 = done_log.size();
    send_cmd(1'b0, 16'h0400, 16'h0000, 11'd2);
    wait_done(d0, 600, err, lat);
    check("post_reset_error", err, 1'b0);
    check("post_reset_master_nack", m_mnack - mn0, 1);
    check_sb("post_reset");

    check("rd_valid_done_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
